sample_feeder: RTL

Upstream producer for the moving-average filter's sample interface. Buffers samples written by a host or capture block in a small FIFO. Replays them as single-cycle data_refresh strobes with din held stable, either at a programmable fixed pace or handshaked against the filter's output_pulse. Used in the filter datapath and in system-level test rigs to drive the filter at a controlled sample rate.

---
 rtl/sample_feeder_if.sv | 31 +++
 rtl/sample_feeder.sv | 81 ++++++++
 2 files changed

// File: rtl/sample_feeder_if.sv
// sample_feeder_if: host write port, run controls, status and filter-side sample strobe
interface sample_feeder_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
);
    localparam int LW = $clog2(DEPTH) + 1;
    logic              enable;
    logic              handshake_mode;
    logic [15:0]       period;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              output_pulse;
    logic              clr_flags;
    logic [DATA_W-1:0] din;
    logic              data_refresh;
    logic              full;
    logic              empty;
    logic [LW-1:0]     level;
    logic [15:0]       issued_cnt;
    logic              overflow;
    logic              underrun;
    logic              timeout;
    modport master (
        output enable, handshake_mode, period, wr_en, wr_data, output_pulse, clr_flags,
        input  din, data_refresh, full, empty, level, issued_cnt, overflow, underrun, timeout
    );
    modport slave (
        input  enable, handshake_mode, period, wr_en, wr_data, output_pulse, clr_flags,
        output din, data_refresh, full, empty, level, issued_cnt, overflow, underrun, timeout
    );
endinterface

// File: rtl/sample_feeder.sv
// sample_feeder: buffers host samples and replays them as paced or handshaked data_refresh strobes
module sample_feeder #(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    sample_feeder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_PERIOD, WAIT_ACK} state_t;
    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [15:0]       cnt, p_load;
    logic [AW:0]       level_n;
    logic              push, expired, timed_out, acked, go_issue;

    // Decide this cycle's write acceptance, ack/timeout and whether the next cycle is a strobe
    always_comb begin
        push      = bus.wr_en && !bus.full;
        expired   = state == WAIT_PERIOD && cnt == 16'd0;
        timed_out = state == WAIT_ACK && !bus.output_pulse && cnt == 16'(TIMEOUT - 1);
        acked     = state == WAIT_ACK && (bus.output_pulse || timed_out);
        go_issue  = bus.enable && !bus.empty && (state == IDLE || expired || acked);
        p_load    = bus.period < 16'd2 ? 16'd0 : bus.period - 16'd2;
        level_n   = bus.level + (AW+1)'(push) - (AW+1)'(go_issue);
    end

    // Sample storage; stale entries are unreachable once the pointers reset
    always_ff @(posedge clk) if (push) mem[wr_ptr] <= bus.wr_data;

    // FIFO pointers, occupancy status and sticky flags (a set beats a same-cycle clear)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            bus.level    <= '0;
            bus.empty    <= 1'b1;
            bus.full     <= 1'b0;
            bus.overflow <= 1'b0;
            bus.underrun <= 1'b0;
            bus.timeout  <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr + AW'(push);
            rd_ptr       <= rd_ptr + AW'(go_issue);
            bus.level    <= level_n;
            bus.empty    <= level_n == '0;
            bus.full     <= level_n == (AW+1)'(DEPTH);
            bus.overflow <= (bus.wr_en && bus.full) || (bus.overflow && !bus.clr_flags);
            bus.underrun <= (expired && bus.empty) || (bus.underrun && !bus.clr_flags);
            bus.timeout  <= timed_out || (bus.timeout && !bus.clr_flags);
        end
    end

    // Strobe FSM: an ack with data pending issues immediately, otherwise waits in WAIT_PERIOD at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            bus.din          <= '0;
            bus.data_refresh <= 1'b0;
            bus.issued_cnt   <= '0;
        end else begin
            state <= !bus.enable ? IDLE :
                     go_issue ? ISSUE :
                     state == ISSUE ? (bus.handshake_mode ? WAIT_ACK : WAIT_PERIOD) :
                     acked ? WAIT_PERIOD : state;
            cnt <= state == ISSUE ? (bus.handshake_mode ? 16'd0 : p_load) :
                   acked ? 16'd0 :
                   state == WAIT_ACK ? cnt + 16'd1 :
                   state == WAIT_PERIOD && !expired ? cnt - 16'd1 : cnt;
            bus.data_refresh <= go_issue;
            if (go_issue) begin
                bus.din        <= mem[rd_ptr];
                bus.issued_cnt <= bus.issued_cnt + 16'd1;
            end
        end
    end
endmodule
